// File: rtl/msg_schedule.sv
// msg_schedule: SHA-256 message schedule generator.
// Takes a 512-bit block on a start pulse and presents one schedule word W_t
// with its round constant K_t per round, advancing when the consumer accepts.
// The schedule is produced with a sliding 16-word window.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_start   in   start pulse, sampled in IDLE only
//   in_block   in   [511:0] message block, W0 in bits 511:480
//   in_next    in   consumer accepts the current word (RUN only)
//   out_Wi     out  [31:0] current schedule word
//   out_Ki     out  [31:0] current round constant
//   out_round  out  [5:0] current round index
//   out_valid  out  word/constant/round valid
//   out_busy   out  high in RUN and DONE
//   out_done   out  one-cycle pulse after round 63 is accepted
//
// state | meaning
// IDLE  | waiting for in_start
// RUN   | presenting rounds 0..63, advancing on in_next
// DONE  | single-cycle completion pulse, then back to IDLE
module msg_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_start,
    input  logic [511:0] in_block,
    input  logic         in_next,
    output logic [31:0]  out_Wi,
    output logic [31:0]  out_Ki,
    output logic [5:0]   out_round,
    output logic         out_valid,
    output logic         out_busy,
    output logic         out_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  round_q, round_d;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic [31:0] new_word;
    logic        load;
    logic        shift;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_start) state_d = ST_RUN;
            ST_RUN:  if (in_next && (round_q == 6'd63)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic; outputs come straight from registers so reset shows at once
    always_comb begin
        out_valid = (state_q == ST_RUN);
        out_busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
        out_done  = (state_q == ST_DONE);
        out_Wi    = w_q[0];
        out_Ki    = K_ROM[round_q];
        out_round = round_q;
    end

    // Window and round counter
    assign load     = (state_q == ST_IDLE) && in_start;
    assign shift    = (state_q == ST_RUN) && in_next && (round_q != 6'd63);
    assign new_word = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

    always_comb begin
        round_d = round_q;
        for (int i = 0; i < 16; i++) begin
            w_d[i] = w_q[i];
        end
        if (load) begin
            round_d = 6'd0;
            for (int i = 0; i < 16; i++) begin
                w_d[i] = in_block[511 - 32*i -: 32];
            end
        end else if (shift) begin
            round_d = round_q + 6'd1;
            for (int i = 0; i < 15; i++) begin
                w_d[i] = w_q[i+1];
            end
            w_d[15] = new_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_q <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'd0;
            end
        end else begin
            round_q <= round_d;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

endmodule

// File: tb/tb_msg_schedule.sv
// Testbench for msg_schedule: directed SHA-256 schedule cases plus random
// blocks with random consumer stalls, checked against a full-array schedule
// model computed directly from the SHA-256 definition.
module tb_msg_schedule;

    logic         clk;
    logic         rst_n;
    logic         in_start;
    logic [511:0] in_block;
    logic         in_next;
    logic [31:0]  out_Wi;
    logic [31:0]  out_Ki;
    logic [5:0]   out_round;
    logic         out_valid;
    logic         out_busy;
    logic         out_done;

    int n_pass  = 0;
    int n_total = 0;

    msg_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_start  (in_start),
        .in_block  (in_block),
        .in_next   (in_next),
        .out_Wi    (out_Wi),
        .out_Ki    (out_Ki),
        .out_round (out_round),
        .out_valid (out_valid),
        .out_busy  (out_busy),
        .out_done  (out_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] ktab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [31:0] obs_w [64];
    logic [31:0] obs_k [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Whole 64-word schedule from the textbook recurrence.
    task automatic sched(input logic [511:0] blk, output logic [31:0] w [64]);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_done"},  64'(out_done),  64'd0);
        chk({tag, "_busy"},  64'(out_busy),  64'd0);
        chk({tag, "_round"}, 64'(out_round), 64'd0);
        chk({tag, "_Wi"},    64'(out_Wi),    64'd0);
        chk({tag, "_Ki"},    64'(out_Ki),    64'h428a2f98);
    endtask

    // Called at a negedge with the DUT in IDLE. mode 0: in_next always 1,
    // mode 1: in_next 0/1 alternating (starting 0), mode 2: random stalls.
    // poke: pulse in_start with a foreign block at round 10.
    // abort_at >= 0: return at that round without finishing.
    task automatic run_block(input logic [511:0] blk, input int mode, input bit poke,
                             input int abort_at, output int done_cyc);
        logic [31:0] ref_w [64];
        int t;
        int cyc;
        bit nx;
        sched(blk, ref_w);
        done_cyc = -1;
        in_block = blk;
        in_start = 1'b1;
        in_next  = 1'($urandom);
        @(negedge clk);
        in_start = 1'b0;
        in_block = rand_block();
        cyc = 1;
        t = 0;
        while (cyc < 400) begin
            if (out_done) begin
                done_cyc = cyc;
                break;
            end
            if (t > 63) begin
                chk("round_overrun", 64'(t), 64'd63);
                break;
            end
            if (t == abort_at) return;
            chk("valid", 64'(out_valid), 64'd1);
            chk("busy",  64'(out_busy),  64'd1);
            chk("round", 64'(out_round), 64'(t));
            chk("W",     64'(out_Wi),    64'(ref_w[t]));
            chk("K",     64'(out_Ki),    64'(ktab[t]));
            obs_w[t] = out_Wi;
            obs_k[t] = out_Ki;
            case (mode)
                0:       nx = 1'b1;
                1:       nx = (cyc % 2 == 0);
                default: nx = ($urandom_range(15) != 0);
            endcase
            if (poke && t == 10) begin
                in_start = 1'b1;
                in_block = ~blk;
            end else begin
                in_start = 1'b0;
            end
            in_next = nx;
            @(negedge clk);
            cyc++;
            if (nx) t++;
        end
        chk("done_seen", 64'(done_cyc > 0), 64'd1);
        chk("done_busy", 64'(out_busy), 64'd1);
        chk("done_valid", 64'(out_valid), 64'd0);
        in_start = 1'b1;   // ignored in DONE
        in_next  = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        chk("idle_busy",  64'(out_busy),  64'd0);
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_done",  64'(out_done),  64'd0);
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] b;
        int dc;

        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;

        rst_n    = 1'b0;
        in_start = 1'b0;
        in_next  = 1'b0;
        in_block = '0;
        #2;
        chk_reset_outputs("rst_async");
        in_start = 1'b1;
        in_next  = 1'b1;
        in_block = rand_block();
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst_held");
        in_start = 1'b0;

        // Release and start on the very first edge afterwards.
        rst_n = 1'b1;
        run_block(abc, 0, 1'b0, -1, dc);
        chk("abc_done_cycle", 64'(dc), 64'd65);
        chk("abc_W0",  64'(obs_w[0]),  64'h61626380);
        chk("abc_W15", 64'(obs_w[15]), 64'h00000018);
        chk("abc_W16", 64'(obs_w[16]), 64'h61626380);
        chk("abc_W17", 64'(obs_w[17]), 64'h000f0000);
        chk("abc_K0",  64'(obs_k[0]),  64'h428a2f98);
        chk("abc_K63", 64'(obs_k[63]), 64'hc67178f2);

        run_block(abc, 1, 1'b0, -1, dc);
        chk("gated_done_cycle", 64'(dc), 64'd129);

        run_block(abc, 0, 1'b1, -1, dc);
        chk("poke_done_cycle", 64'(dc), 64'd65);

        // Mid-block reset at round 30.
        run_block(rand_block(), 2, 1'b0, 30, dc);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        #1 rst_n = 1'b1;
        in_next = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_done",  64'(out_done),  64'd0);
            chk("post_rst_valid", 64'(out_valid), 64'd0);
        end
        b = rand_block();
        run_block(b, 2, 1'b0, -1, dc);

        // Back-to-back: the task returns in the first IDLE cycle.
        run_block(rand_block(), 2, 1'b0, -1, dc);
        run_block(rand_block(), 0, 1'b0, -1, dc);
        chk("b2b_done_cycle", 64'(dc), 64'd65);

        for (int n = 0; n < 1000; n++) begin
            run_block(rand_block(), 2, ($urandom_range(7) == 0), -1, dc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
